// File: rtl/if_fetch_unit_if.sv
// Purpose : bundle of the fetch unit's memory, redirect and IF/ID signals.
// Latency : none (wires only).
// Backpressure: p_IMEM_Ack gates requests; p_IF_ID_Stall holds the IF/ID head.
// Ports   : master = fetch unit side, slave = memory / pipeline side.
interface if_fetch_unit_if #(
   parameter int WIDTH = 64
);
   logic             p_IMEM_Req;
   logic [WIDTH-1:0] p_IMEM_Addr;
   logic             p_IMEM_Ack;
   logic             p_IMEM_Rsp_Valid;
   logic [WIDTH-1:0] p_IMEM_Rsp_Data;
   logic             p_Redirect_Valid;
   logic [WIDTH-1:0] p_Redirect_PC;
   logic             p_IF_ID_Stall;
   logic [WIDTH-1:0] p_IF_Instruction;
   logic [WIDTH-1:0] p_IF_PC_Counter;
   logic             p_IF_ID_Flush;

   modport master (
      output p_IMEM_Req, p_IMEM_Addr, p_IF_Instruction, p_IF_PC_Counter, p_IF_ID_Flush,
      input  p_IMEM_Ack, p_IMEM_Rsp_Valid, p_IMEM_Rsp_Data, p_Redirect_Valid,
             p_Redirect_PC, p_IF_ID_Stall
   );

   modport slave (
      input  p_IMEM_Req, p_IMEM_Addr, p_IF_Instruction, p_IF_PC_Counter, p_IF_ID_Flush,
      output p_IMEM_Ack, p_IMEM_Rsp_Valid, p_IMEM_Rsp_Data, p_Redirect_Valid,
             p_Redirect_PC, p_IF_ID_Stall
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Purpose : instruction-fetch front end; owns the PC, issues in-order fetches, feeds IF/ID.
// Latency : response visible to IF/ID one cycle after it returns; bubble (0/0) when empty.
// Backpressure: buffered + outstanding fetches capped at BUF_DEPTH; p_IF_ID_Stall holds the head.
// Ports   : p_clk, p_reset (async, active-high); bus = if_fetch_unit_if.master.
// Option  : define IF_FETCH_PERF_EN to add saturating bubble/redirect/drop counters.
module if_fetch_unit #(
   parameter int               WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter int               BUF_DEPTH = 2
) (
   input  logic                  p_clk,
   input  logic                  p_reset,
   if_fetch_unit_if.master       bus
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]           p_IF_Bubble_Cnt,
   output logic [31:0]           p_IF_Redirect_Cnt,
   output logic [31:0]           p_IF_Drop_Cnt
`endif
);
   localparam int IW = $clog2(BUF_DEPTH);
   localparam int PW = IW + 1;

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]    outst_q, outst_d;
   logic [PW-1:0]    drop_q, drop_d;
   logic [PW-1:0]    rd_q, rd_d;          // shared head pointer of both FIFOs
   logic [PW-1:0]    instr_wr_q, instr_wr_d;
   logic [PW-1:0]    pc_wr_q, pc_wr_d;
   logic [WIDTH-1:0] instr_mem_q [BUF_DEPTH];
   logic [WIDTH-1:0] instr_mem_d [BUF_DEPTH];
   logic [WIDTH-1:0] pc_mem_q [BUF_DEPTH];
   logic [WIDTH-1:0] pc_mem_d [BUF_DEPTH];
   logic             flush_q, flush_d;

   logic [PW-1:0]    count;
   logic [PW:0]      used_slots;
   logic             fifo_empty, imem_req, hs, rsp, redir, pop, dropped;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      outst_d     = outst_q;
      drop_d      = drop_q;
      rd_d        = rd_q;
      instr_wr_d  = instr_wr_q;
      pc_wr_d     = pc_wr_q;
      instr_mem_d = instr_mem_q;
      pc_mem_d    = pc_mem_q;
      flush_d     = 1'b0;

      count      = instr_wr_q - rd_q;
      fifo_empty = (count == '0);
      used_slots = {1'b0, count} + {1'b0, outst_q};
      imem_req   = (state_q == ST_RUN) && (used_slots < (PW+1)'(BUF_DEPTH));
      hs         = imem_req && bus.p_IMEM_Ack;
      // Memory is reset with us, so a response is only meaningful while one is owed.
      rsp        = bus.p_IMEM_Rsp_Valid && (outst_q != '0);
      redir      = bus.p_Redirect_Valid;
      pop        = !fifo_empty && !bus.p_IF_ID_Stall;
      dropped    = rsp && (redir || (state_q == ST_DRAIN));

      outst_d = outst_q + PW'(hs) - PW'(rsp);

      // The PC FIFO is written at request time, so it runs ahead of the instruction FIFO;
      // both share rd_q and index by position, keeping each instruction paired with its PC.
      if (hs) begin
         pc_mem_d[pc_wr_q[IW-1:0]] = fetch_pc_q;
         pc_wr_d    = pc_wr_q + 1'b1;
         fetch_pc_d = fetch_pc_q + WIDTH'(4);
      end

      if (rsp && !redir && (state_q == ST_RUN)) begin
         instr_mem_d[instr_wr_q[IW-1:0]] = bus.p_IMEM_Rsp_Data;
         instr_wr_d = instr_wr_q + 1'b1;
      end

      if (pop) rd_d = rd_q + 1'b1;

      case (state_q)
         ST_BOOT:  state_d = ST_RUN;
         ST_DRAIN: begin
            if (rsp) drop_d = drop_q - 1'b1;
            if (drop_d == '0) state_d = ST_RUN;
         end
         default:  ;
      endcase

      if (redir) begin
         fetch_pc_d = {bus.p_Redirect_PC[WIDTH-1:2], 2'b00};
         // Empty both FIFOs; PCs of in-flight requests go too, since their data is dropped.
         rd_d       = pc_wr_d;
         instr_wr_d = pc_wr_d;
         drop_d     = outst_d;
         flush_d    = 1'b1;
         if (state_q != ST_BOOT)
            state_d = (outst_d != '0) ? ST_DRAIN : ST_RUN;
      end
   end

   always_ff @(posedge p_clk or posedge p_reset) begin
      if (p_reset) begin
         state_q    <= ST_BOOT;
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
         rd_q       <= '0;
         instr_wr_q <= '0;
         pc_wr_q    <= '0;
         flush_q    <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            instr_mem_q[i] <= '0;
            pc_mem_q[i]    <= '0;
         end
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         outst_q     <= outst_d;
         drop_q      <= drop_d;
         rd_q        <= rd_d;
         instr_wr_q  <= instr_wr_d;
         pc_wr_q     <= pc_wr_d;
         flush_q     <= flush_d;
         instr_mem_q <= instr_mem_d;
         pc_mem_q    <= pc_mem_d;
      end
   end

   assign bus.p_IMEM_Req       = imem_req;
   assign bus.p_IMEM_Addr      = fetch_pc_q;
   assign bus.p_IF_Instruction = fifo_empty ? '0 : instr_mem_q[rd_q[IW-1:0]];
   assign bus.p_IF_PC_Counter  = fifo_empty ? '0 : pc_mem_q[rd_q[IW-1:0]];
   assign bus.p_IF_ID_Flush    = flush_q;

`ifdef IF_FETCH_PERF_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic [31:0] redir_cnt_q, redir_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      redir_cnt_d  = redir_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      if (fifo_empty && !bus.p_IF_ID_Stall && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 1'b1;
      if (redir && (redir_cnt_q != '1))                              redir_cnt_d  = redir_cnt_q + 1'b1;
      if (dropped && (drop_cnt_q != '1))                             drop_cnt_d   = drop_cnt_q + 1'b1;
   end

   always_ff @(posedge p_clk or posedge p_reset) begin
      if (p_reset) begin
         bubble_cnt_q <= '0;
         redir_cnt_q  <= '0;
         drop_cnt_q   <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         redir_cnt_q  <= redir_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign p_IF_Bubble_Cnt   = bubble_cnt_q;
   assign p_IF_Redirect_Cnt = redir_cnt_q;
   assign p_IF_Drop_Cnt     = drop_cnt_q;
`else
   logic unused_dropped;
   assign unused_dropped = dropped;
`endif
endmodule
